// File: rtl/bip_control_unit.sv
// bip_control_unit: BIP instruction sequencer running a FETCH/DECODE/EXEC/HALT loop.
// Optional single-step gating of FETCH when BIP_STEP_EN is defined.
`default_nettype none

module bip_control_unit #(
  parameter int PC_W   = 11,
  parameter int ICNT_W = 16
) (
  input  logic              CLK,
  input  logic              RESET,
`ifdef BIP_STEP_EN
  input  logic              STEP,
`endif
  input  logic [15:0]       INSTR,
  output logic [PC_W-1:0]   PC_ADDR,
  output logic [10:0]       OPERAND,
  output logic [1:0]        SEL_A,
  output logic              SEL_B,
  output logic              OP,
  output logic              WR_ACC,
  output logic              WR_RAM,
  output logic              RD_RAM,
  output logic              HALTED,
  output logic              ILLEGAL,
  output logic [ICNT_W-1:0] INSTR_COUNT
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  localparam logic [4:0] c_OP_HLT  = 5'b00000;
  localparam logic [4:0] c_OP_STO  = 5'b00001;
  localparam logic [4:0] c_OP_LD   = 5'b00010;
  localparam logic [4:0] c_OP_LDI  = 5'b00011;
  localparam logic [4:0] c_OP_ADD  = 5'b00100;
  localparam logic [4:0] c_OP_ADDI = 5'b00101;
  localparam logic [4:0] c_OP_SUB  = 5'b00110;
  localparam logic [4:0] c_OP_SUBI = 5'b00111;

  localparam logic [PC_W-1:0]   c_PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [ICNT_W-1:0] c_ICNT_ONE = {{(ICNT_W-1){1'b0}}, 1'b1};
  localparam logic [ICNT_W-1:0] c_ICNT_MAX = {ICNT_W{1'b1}};

  state_t              r_state;
  logic [PC_W-1:0]     r_pc;
  logic [15:0]         r_ir;
  logic [1:0]          r_sel_a;
  logic                r_sel_b;
  logic                r_op;
  logic                r_wr_acc;
  logic                r_wr_ram;
  logic                r_rd_ram;
  logic                r_halted;
  logic                r_illegal;
  logic [ICNT_W-1:0]   r_icnt;

  logic                w_step;
  logic [4:0]          w_opc;

`ifdef BIP_STEP_EN
  assign w_step = STEP;
`else
  assign w_step = 1'b1;
`endif

  assign w_opc = INSTR[15:11];

  // Controls are loaded on the DECODE->EXEC edge straight from INSTR so they
  // are registered for the single EXEC cycle and cleared on the next edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= S_FETCH;
      r_pc      <= '0;
      r_ir      <= '0;
      r_sel_a   <= 2'b00;
      r_sel_b   <= 1'b0;
      r_op      <= 1'b0;
      r_wr_acc  <= 1'b0;
      r_wr_ram  <= 1'b0;
      r_rd_ram  <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_icnt    <= '0;
    end else begin
      r_sel_a  <= 2'b00;
      r_sel_b  <= 1'b0;
      r_op     <= 1'b0;
      r_wr_acc <= 1'b0;
      r_wr_ram <= 1'b0;
      r_rd_ram <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (w_step) r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_ir    <= INSTR;
          r_state <= S_EXEC;
          case (w_opc)
            c_OP_HLT: ;
            c_OP_STO: r_wr_ram <= 1'b1;
            c_OP_LD: begin
              r_rd_ram <= 1'b1;
              r_wr_acc <= 1'b1;
            end
            c_OP_LDI: begin
              r_sel_a  <= 2'b01;
              r_wr_acc <= 1'b1;
            end
            c_OP_ADD, c_OP_SUB: begin
              r_rd_ram <= 1'b1;
              r_op     <= (w_opc == c_OP_SUB);
              r_sel_a  <= 2'b10;
              r_wr_acc <= 1'b1;
            end
            c_OP_ADDI, c_OP_SUBI: begin
              r_sel_b  <= 1'b1;
              r_op     <= (w_opc == c_OP_SUBI);
              r_sel_a  <= 2'b10;
              r_wr_acc <= 1'b1;
            end
            default: r_illegal <= 1'b1;
          endcase
        end
        S_EXEC: begin
          if (r_ir[15:11] == c_OP_HLT) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_pc    <= r_pc + c_PC_ONE;
            if (r_icnt != c_ICNT_MAX) r_icnt <= r_icnt + c_ICNT_ONE;
            r_state <= S_FETCH;
          end
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign PC_ADDR     = r_pc;
  assign OPERAND     = r_ir[10:0];
  assign SEL_A       = r_sel_a;
  assign SEL_B       = r_sel_b;
  assign OP          = r_op;
  assign WR_ACC      = r_wr_acc;
  assign WR_RAM      = r_wr_ram;
  assign RD_RAM      = r_rd_ram;
  assign HALTED      = r_halted;
  assign ILLEGAL     = r_illegal;
  assign INSTR_COUNT = r_icnt;

endmodule

`default_nettype wire
